// File: rtl/register_bank_if.sv
// register_bank_if: bus bundle for the general-purpose register bank.
//   master : drives E, RegSel, FunSel, I, OutASel, OutBSel; reads OutA/OutB/Wrap/Packed
//   slave  : the register bank itself
// Clock and Reset are plain ports on the bank and are not carried here.
interface register_bank_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4,
  parameter int SELW  = 4
);
  logic             E;
  logic [NREGS-1:0] RegSel;
  logic [2:0]       FunSel;
  logic [WIDTH-1:0] I;
  logic [SELW-1:0]  OutASel;
  logic [SELW-1:0]  OutBSel;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic [NREGS-1:0] Wrap;
  logic [NREGS-1:0] Packed;

  modport master (
    output E, RegSel, FunSel, I, OutASel, OutBSel,
    input  OutA, OutB, Wrap, Packed
  );

  modport slave (
    input  E, RegSel, FunSel, I, OutASel, OutBSel,
    output OutA, OutB, Wrap, Packed
  );
endinterface

// File: rtl/register_bank.sv
// register_bank: NREGS x WIDTH general-purpose register file with the 3-bit
// FunSel operation set, per-register select, two combinational read ports,
// a sticky wrap flag and a byte-packing counter per register.
//
// Ports:
//   Clock   rising-edge clock
//   Reset   synchronous active-low reset (clears registers, Wrap, byte counters)
//   bus     register_bank_if.slave:
//             E/RegSel/FunSel/I      write side
//             OutASel/OutBSel        read indices (index >= NREGS reads 0)
//             OutA/OutB              read data
//             Wrap/Packed            per-register status, registered
//
// Parameters: WIDTH (multiple of 8, >= 16), NREGS (2..16), SELW (2**SELW >= NREGS).
//
// Optional feature macro: REGBANK_BYPASS_EN
//   defined   : read ports forward the value a selected register will take at
//               the coming edge (0 while Reset is low)
//   undefined : read ports show stored contents only

// One register with its wrap flag and byte counter.
module register_bank_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [2:0]       fun_sel_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] view_o,
  output logic             wrap_o,
  output logic             packed_o
);
  localparam int BCMAX = WIDTH / 8;
  localparam int BCW   = $clog2(BCMAX + 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(BCMAX);

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_ZX8   = 3'b100;
  localparam logic [2:0] FS_ZX16  = 3'b101;
  localparam logic [2:0] FS_SHIFT = 3'b110;
  localparam logic [2:0] FS_SX16  = 3'b111;

  logic [WIDTH-1:0] r_q, r_d;
  logic             wrap_q, wrap_d;
  logic [BCW-1:0]   bc_q, bc_d;

  // Candidate next state; only committed when the lane is write-enabled.
  always_comb begin
    r_d    = r_q;
    wrap_d = wrap_q;
    bc_d   = bc_q;
    case (fun_sel_i)
      FS_DEC: begin
        r_d = r_q - WIDTH'(1);
        if (r_q == '0) wrap_d = 1'b1;
      end
      FS_INC: begin
        r_d = r_q + WIDTH'(1);
        if (&r_q) wrap_d = 1'b1;
      end
      FS_LOAD: begin
        r_d = din_i; wrap_d = 1'b0; bc_d = '0;
      end
      FS_CLR: begin
        r_d = '0; wrap_d = 1'b0; bc_d = '0;
      end
      FS_ZX8: begin
        r_d = {{(WIDTH-8){1'b0}}, din_i[7:0]}; wrap_d = 1'b0; bc_d = '0;
      end
      FS_ZX16: begin
        r_d = {{(WIDTH-16){1'b0}}, din_i[15:0]}; wrap_d = 1'b0; bc_d = '0;
      end
      FS_SHIFT: begin
        // Keeps shifting after the counter saturates; Packed just stays high.
        r_d = {r_q[WIDTH-9:0], din_i[7:0]};
        if (bc_q != BC_FULL) bc_d = bc_q + BCW'(1);
      end
      FS_SX16: begin
        r_d = {{(WIDTH-16){din_i[15]}}, din_i[15:0]}; wrap_d = 1'b0; bc_d = '0;
      end
      default: begin
        r_d = r_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q    <= '0;
      wrap_q <= 1'b0;
      bc_q   <= '0;
    end else if (we_i) begin
      r_q    <= r_d;
      wrap_q <= wrap_d;
      bc_q   <= bc_d;
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Forward the result being computed this cycle; a pending reset reads as 0.
  always_comb begin
    view_o = r_q;
    if (!rst_ni)   view_o = '0;
    else if (we_i) view_o = r_d;
  end
`else
  assign view_o = r_q;
`endif

  assign wrap_o   = wrap_q;
  assign packed_o = (bc_q == BC_FULL);
endmodule

module register_bank #(
  parameter int WIDTH = 32,
  parameter int NREGS = 4,
  parameter int SELW  = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  register_bank_if.slave bus
);
  logic [NREGS-1:0][WIDTH-1:0] view;
  logic [NREGS-1:0]            wrap;
  logic [NREGS-1:0]            pk;
  logic [WIDTH-1:0]            out_a, out_b;

  for (genvar k = 0; k < NREGS; k++) begin : g_lane
    register_bank_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_i    (Clock),
      .rst_ni   (Reset),
      .we_i     (bus.E & bus.RegSel[k]),
      .fun_sel_i(bus.FunSel),
      .din_i    (bus.I),
      .view_o   (view[k]),
      .wrap_o   (wrap[k]),
      .packed_o (pk[k])
    );
  end

  // Read muxes; indices with no register behind them fall through to 0.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (bus.OutASel == SELW'(k)) out_a = view[k];
      if (bus.OutBSel == SELW'(k)) out_b = view[k];
    end
  end

  assign bus.OutA   = out_a;
  assign bus.OutB   = out_b;
  assign bus.Wrap   = wrap;
  assign bus.Packed = pk;
endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  register_bank_if #(.WIDTH(32), .NREGS(4), .SELW(4)) bus ();

  register_bank #(.WIDTH(32), .NREGS(4), .SELW(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  // ---------------- behavioural model ----------------
  logic [31:0] m_r [4];
  logic [3:0]  m_wrap;
  int          m_bc [4];
  bit          m_ok = 0;

  function automatic logic [31:0] f_next(logic [31:0] r, logic [2:0] f, logic [31:0] d);
    case (f)
      3'd0: return r - 32'd1;
      3'd1: return r + 32'd1;
      3'd2: return d;
      3'd3: return 32'd0;
      3'd4: return d & 32'h0000_00FF;
      3'd5: return d & 32'h0000_FFFF;
      3'd6: return (r << 8) | (d & 32'h0000_00FF);
      default: return d[15] ? (32'hFFFF_0000 | d) : (d & 32'h0000_FFFF);
    endcase
  endfunction

  always @(posedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < 4; k++) begin
        m_r[k]  <= 32'd0;
        m_bc[k] <= 0;
      end
      m_wrap <= 4'd0;
      m_ok   <= 1'b1;
    end else if (bus.E) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.RegSel[k]) begin
          m_r[k] <= f_next(m_r[k], bus.FunSel, bus.I);
          if (bus.FunSel == 3'd0 && m_r[k] == 32'd0) m_wrap[k] <= 1'b1;
          else if (bus.FunSel == 3'd1 && m_r[k] == 32'hFFFF_FFFF) m_wrap[k] <= 1'b1;
          else if (bus.FunSel >= 3'd2 && bus.FunSel != 3'd6) m_wrap[k] <= 1'b0;
          if (bus.FunSel == 3'd6) m_bc[k] <= (m_bc[k] < 4) ? m_bc[k] + 1 : 4;
          else if (bus.FunSel >= 3'd2) m_bc[k] <= 0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_port(logic [3:0] sel);
    if (sel >= 4) return 32'd0;
`ifdef REGBANK_BYPASS_EN
    if (!Reset) return 32'd0;
    if (bus.E && bus.RegSel[sel[1:0]]) return f_next(m_r[sel[1:0]], bus.FunSel, bus.I);
`endif
    return m_r[sel[1:0]];
  endfunction

  function automatic logic [3:0] exp_packed();
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = (m_bc[k] == 4);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, between active edges.
  always @(negedge Clock) begin
    if (m_ok) begin
      chk("cyc_OutA",   bus.OutA,          exp_port(bus.OutASel));
      chk("cyc_OutB",   bus.OutB,          exp_port(bus.OutBSel));
      chk("cyc_Wrap",   {28'd0, bus.Wrap},   {28'd0, m_wrap});
      chk("cyc_Packed", {28'd0, bus.Packed}, {28'd0, exp_packed()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic op(input logic [3:0] rs, input logic [2:0] fs, input logic [31:0] d);
    bus.E = 1'b1; bus.RegSel = rs; bus.FunSel = fs; bus.I = d;
    @(posedge Clock); #1;
    bus.E = 1'b0; bus.RegSel = 4'd0;
  endtask

  task automatic rd(input int k, input string nm, input logic [31:0] exp);
    bus.OutASel = 4'(k); bus.OutBSel = 4'(k);
    #1;
    chk({nm, "_A"}, bus.OutA, exp);
    chk({nm, "_B"}, bus.OutB, exp);
  endtask

  initial begin
    bus.E = 1'b0; bus.RegSel = 4'd0; bus.FunSel = 3'd0; bus.I = 32'd0;
    bus.OutASel = 4'd0; bus.OutBSel = 4'd1;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    // Reset after arbitrary loads
    op(4'b0001, 3'd2, 32'hA5A5_0001);
    op(4'b0010, 3'd2, 32'h1234_5678);
    op(4'b1100, 3'd6, 32'h0000_00EE);
    op(4'b1000, 3'd2, 32'hFFFF_FFFF);
    op(4'b1000, 3'd1, 32'd0);
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    for (int k = 0; k < 4; k++) rd(k, $sformatf("rst_R%0d", k), 32'd0);
    chk("rst_Wrap",   {28'd0, bus.Wrap},   32'd0);
    chk("rst_Packed", {28'd0, bus.Packed}, 32'd0);

    // Wrap on decrement / increment / clear
    op(4'b0010, 3'd0, 32'd0);
    rd(1, "dec_R1", 32'hFFFF_FFFF);
    chk("dec_Wrap", {28'd0, bus.Wrap}, 32'h2);
    op(4'b0010, 3'd1, 32'd0);
    rd(1, "inc_R1", 32'd0);
    chk("inc_Wrap", {28'd0, bus.Wrap}, 32'h2);
    op(4'b0010, 3'd3, 32'd0);
    chk("clr_Wrap", {28'd0, bus.Wrap}, 32'h0);
    op(4'b1000, 3'd2, 32'hFFFF_FFFF);
    op(4'b1000, 3'd1, 32'd0);
    rd(3, "incwrap_R3", 32'd0);
    chk("incwrap_Wrap", {28'd0, bus.Wrap}, 32'h8);

    // Byte packing on R2
    op(4'b0100, 3'd6, 32'hFFFF_FF11);
    chk("pk1", {28'd0, bus.Packed}, 32'h0);
    op(4'b0100, 3'd6, 32'h0000_0022);
    chk("pk2", {28'd0, bus.Packed}, 32'h0);
    op(4'b0100, 3'd6, 32'h0000_0033);
    chk("pk3", {28'd0, bus.Packed}, 32'h0);
    op(4'b0100, 3'd6, 32'h0000_0044);
    chk("pk4", {28'd0, bus.Packed}, 32'h4);
    rd(2, "pk4_R2", 32'h1122_3344);
    op(4'b0100, 3'd6, 32'h0000_0055);
    chk("pk5", {28'd0, bus.Packed}, 32'h4);
    rd(2, "pk5_R2", 32'h2233_4455);

    // Multiple select with extension ops
    op(4'b1001, 3'd7, 32'h0000_8001);
    rd(0, "sx_R0", 32'hFFFF_8001);
    rd(3, "sx_R3", 32'hFFFF_8001);
    rd(1, "sx_R1", 32'd0);
    rd(2, "sx_R2", 32'h2233_4455);
    chk("sx_Wrap", {28'd0, bus.Wrap}, 32'h0);
    op(4'b1001, 3'd4, 32'h0000_ABCD);
    rd(0, "zx_R0", 32'h0000_00CD);
    rd(3, "zx_R3", 32'h0000_00CD);
    op(4'b0010, 3'd5, 32'hFFFF_ABCD);
    rd(1, "zx16_R1", 32'h0000_ABCD);

    // Gating: E=0 changes nothing
    bus.RegSel = 4'b1111; bus.FunSel = 3'd2; bus.I = 32'h1234_5678; bus.E = 1'b0;
    @(posedge Clock); #1;
    bus.RegSel = 4'd0;
    rd(0, "gate_R0", 32'h0000_00CD);
    rd(2, "gate_R2", 32'h2233_4455);

    // Invalid index
    bus.OutASel = 4'd5; bus.OutBSel = 4'd15; #1;
    chk("idx5_OutA",  bus.OutA, 32'd0);
    chk("idx15_OutB", bus.OutB, 32'd0);

    // Reset takes precedence over a load
    Reset = 1'b0;
    op(4'b0001, 3'd2, 32'hCAFE_F00D);
    Reset = 1'b1;
    rd(0, "rstprec_R0", 32'd0);

    // Same-cycle visibility of a load
    bus.OutASel = 4'd0; bus.OutBSel = 4'd1;
    bus.E = 1'b1; bus.RegSel = 4'b0001; bus.FunSel = 3'd2; bus.I = 32'hDEAD_BEEF;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("byp_pre_OutA", bus.OutA, 32'hDEAD_BEEF);
`else
    chk("byp_pre_OutA", bus.OutA, 32'd0);
`endif
    @(posedge Clock); #1;
    bus.E = 1'b0; bus.RegSel = 4'd0;
    chk("byp_post_OutA", bus.OutA, 32'hDEAD_BEEF);

    // Mixed traffic checked by the per-cycle compare
    for (int n = 0; n < 60; n++) begin
      bus.E       = ($urandom_range(0, 3) != 0);
      bus.RegSel  = 4'($urandom_range(0, 15));
      bus.FunSel  = 3'($urandom_range(0, 7));
      bus.I       = $urandom;
      bus.OutASel = 4'($urandom_range(0, 6));
      bus.OutBSel = 4'($urandom_range(0, 6));
      Reset       = ($urandom_range(0, 19) != 0);
      @(posedge Clock); #1;
    end
    Reset = 1'b1; bus.E = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of NREGS general-purpose registers of WIDTH bits. It is the successor to the single fixed 32-bit function-select register and keeps the same 3-bit FunSel operation encoding, generalised to any width. Over the single register it adds:
- per-register select, so several registers can take one operation in the same cycle;
- two independent read ports;
- a sticky wrap flag per register;
- a byte-packing counter for the shift-in operation.

It sits in the datapath as the general-purpose register file, feeding the ALU operand muxes.

## Interface
Parameters:
- WIDTH, default 32, register width in bits; must be a multiple of 8 and ≥ 16.
- NREGS, default 4, number of registers; 2..16.
- SELW, default 4, width of the read-select ports; must satisfy 2^SELW ≥ NREGS.

Ports:
- Clock  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-low reset.
- E  in  1  global write enable; when 0, no register, flag or counter changes.
- RegSel  in  NREGS  one bit per register; 1 means register k executes FunSel this cycle.
- FunSel  in  3  operation code (see Operation).
- I  in  WIDTH  data input.
- OutASel  in  SELW  read port A register index.
- OutBSel  in  SELW  read port B register index.
- OutA  out  WIDTH  contents of R[OutASel]; 0 if the index ≥ NREGS.
- OutB  out  WIDTH  contents of R[OutBSel]; 0 if the index ≥ NREGS.
- Wrap  out  NREGS  sticky increment/decrement wrap flag per register.
- Packed  out  NREGS  1 when register k has received WIDTH/8 consecutive byte shifts.

## Operation
- Register k updates at a rising Clock edge when Reset=1, E=1 and RegSel[k]=1.
- Unselected registers hold their value, Wrap flag and byte counter.
- FunSel codes:
  - 000: R ← R−1, modulo 2^WIDTH.
  - 001: R ← R+1, modulo 2^WIDTH.
  - 010: R ← I.
  - 011: R ← 0.
  - 100: R ← zero-extended I[7:0].
  - 101: R ← zero-extended I[15:0].
  - 110: R ← {R[WIDTH-9:0], I[7:0]} (8-bit left shift, byte in at the LSB).
  - 111: R ← sign-extended I[15:0].
- Wrap[k]:
  - Set by 000 when R=0, and by 001 when R is all-ones.
  - Cleared by 010, 011, 100, 101 and 111.
  - Unchanged by 110, and by 000/001 that do not wrap.
- Byte counter BC[k], range 0..WIDTH/8:
  - 110 increments BC[k], saturating at WIDTH/8.
  - 010, 011, 100, 101 and 111 reset BC[k] to 0.
  - 000 and 001 leave BC[k] unchanged.
- Packed[k] = (BC[k] == WIDTH/8). Shifts after saturation keep shifting R while Packed stays 1.
- Multiple RegSel bits set: each selected register performs the operation independently on its own value and flags.
- RegSel = 0 with E = 1: no state change.
- Read ports are combinational muxes. OutASel may equal OutBSel.
- Unknown-free: every state element has a defined reset value.

## Timing
- Reset=0 at a rising edge clears all registers, Wrap and BC to 0, regardless of E and RegSel. Reset has priority over every operation.
- Outputs after reset: OutA = 0, OutB = 0, Wrap = 0, Packed = 0.
- Reset asserted mid byte-packing sequence discards the partial word; BC returns to 0.
- Write latency: the result of an operation presented before edge n is visible on OutA/OutB after edge n (one cycle), unless bypass is enabled (see Configuration).
- Wrap and Packed update on the same edge as the register and are visible after it.
- Read-select changes affect OutA/OutB within the same cycle (combinational, zero latency).

## Configuration
- Macro: REGBANK_BYPASS_EN.
- Defined: write-forwarding on both read ports. When the read index equals a register that is selected with E=1 and Reset=1, the port shows the value that register will hold after the coming edge, so a result is readable in the same cycle it is computed. When Reset=0, the ports show 0.
- Undefined: the ports show only the stored register contents; there is no combinational path from I, FunSel, RegSel or E to OutA/OutB.
- Wrap and Packed are always registered in both builds.

## Test plan
All cases use WIDTH=32, NREGS=4.
- Reset: hold Reset=0 for 2 edges after arbitrary loads → every register reads 0x00000000 on both ports; Wrap=4'b0000; Packed=4'b0000.
- Wrap on decrement: R1=0, then FunSel=000 with RegSel=4'b0010 → R1=0xFFFFFFFF and Wrap[1]=1. A following 001 → R1=0, Wrap[1] stays 1. A following 011 → Wrap[1]=0.
- Byte packing: 4× FunSel=110 on R2 with I[7:0]=0x11, 0x22, 0x33, 0x44 → R2=0x11223344 and Packed[2]=1 after the 4th edge, 0 after edges 1–3. A 5th shift with 0x55 → R2=0x22334455, Packed[2] stays 1.
- Multiple select and extension ops:
  - RegSel=4'b1001 with FunSel=111 and I=0x00008001 → R0=R3=0xFFFF8001; R1 and R2 unchanged.
  - Same RegSel with FunSel=100 and I=0xABCD → both read 0x000000CD.
- Gating, invalid index and reset precedence:
  - E=0 with FunSel=010 → no change anywhere.
  - OutASel=5 → OutA=0.
  - Reset=0 together with E=1 and a load → register reads 0.
- Bypass (REGBANK_BYPASS_EN defined): OutASel=0, FunSel=010, I=0xDEADBEEF, RegSel=4'b0001 → OutA=0xDEADBEEF before the edge. Without the macro → old value until after the edge.
